ip_rx_parser: RTL and testbench
===============================

Name: ip_rx_parser

Overview:
- IPv4/UDP receive-side parser for the 100M MII Ethernet path; the counterpart of the nibble-serial IP transmitter.
- Sits after the MAC receiver, which has already stripped preamble, SFD, MAC addresses and type 0x0800. It consumes the IP datagram as a nibble stream.
- Validates the 20-byte IPv4 header, including a one's-complement checksum.
- Forwards only the payload nibbles (UDP header plus data) into a write-side FIFO, and reports per-datagram status.

Parameters:
- LOCAL_IP, 32'hc0a88958, IPv4 address accepted as destination.
- CHECK_DST, 1, 1 = drop datagrams whose destination IP is not LOCAL_IP; 0 = accept any destination.

Ports:
- mii_rx_clk  input  1  25 MHz MII receive clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pkt_dv  input  1  nibble valid from MAC receiver. High contiguously for one datagram plus any Ethernet padding; its falling edge marks end of frame.
- pkt_da  input  4  data nibble; low nibble of each byte first.
- fifo_wr  output  1  payload FIFO write strobe.
- fifo_wd  output  4  payload nibble, low nibble first.
- pay_len  output  16  payload byte count = tot_len - 20. Valid from hdr_ok until the next datagram starts.
- src_ip  output  32  captured source IP. Same validity as pay_len.
- hdr_ok  output  1  one-cycle pulse: header accepted.
- pkt_done  output  1  one-cycle pulse: datagram finished (good or bad).
- pkt_err  output  1  qualifies pkt_done; 1 = datagram bad.
- err_code  output  3  error cause, held until the next datagram starts.

Behaviour:
- Reset: every output is 0, the state is IDLE and all counters are 0. Reset asserted mid-datagram aborts the datagram with no pulses. After release, the block waits for pkt_dv low before accepting the next frame.
- States:
  - IDLE -> HDR on pkt_dv=1. That first nibble is header nibble 0.
  - HDR counts nibbles 0..39; byte k = {nibble 2k+1, nibble 2k}.
  - At nibble 39, go to PAYLOAD if the header is good, otherwise to DROP.
  - PAYLOAD runs while the remaining-nibble counter (loaded with 2*pay_len) is nonzero. Each valid nibble decrements it.
  - When the counter reaches 0 -> DROP. Ethernet padding is discarded there.
  - DROP -> IDLE on pkt_dv=0.
- End of frame: pkt_dv=0 in any non-IDLE state ends the datagram.
- Header checks are evaluated on nibble 39. Priority is lowest code first:
  - 1: byte0 != 0x45.
  - 2: protocol (byte 9) != 17.
  - 3: CHECK_DST=1 and destination != LOCAL_IP.
  - 4: checksum bad.
  - 5: tot_len < 20, or MF flag set, or fragment offset != 0.
- Runt/truncation errors:
  - 6 (runt): pkt_dv falls during HDR.
  - 7 (truncated): pkt_dv falls during PAYLOAD with the counter nonzero.
- Checksum: 16-bit words are {byte 2j, byte 2j+1}, j = 0..9, including the checksum field.
  - Accumulate into a 20-bit sum, fold carries twice, then compare.
  - Good iff the folded result == 16'hFFFF.
- Header result timing: hdr_ok, or pkt_done with pkt_err=1, pulses one cycle after nibble 39 is sampled.
- Payload latency: fifo_wr/fifo_wd are registered, one cycle after the nibble is sampled.
  - No writes ever occur in HDR or DROP, or after the counter reaches 0.
  - pay_len=0 gives an immediate good pkt_done with no writes.
- Good completion: pkt_done, pkt_err=0 pulses one cycle after the last payload nibble is sampled, coincident with its fifo_wr.
- Truncation completion: pkt_done, pkt_err=1, err_code=7 pulses one cycle after pkt_dv falls. Nibbles already written stay written; the downstream consumer discards them using pkt_err.
- pkt_done pulses exactly once per datagram.
- Runt completion: pkt_done/pkt_err pulse one cycle after pkt_dv falls, with err_code=6.
- A new frame (pkt_dv rising) clears err_code.
- No back-pressure: the FIFO must absorb 25M nibbles/s.

Test Plan:
- Good datagram:
  - Stimulus: header words 4500 001C 21B3 0000 4011 C573 C0A8 8901 C0A8 8958, then 16 payload nibbles 0..F.
  - Required: hdr_ok 1 cycle after nibble 39; pay_len=8; src_ip=c0a88901; 16 fifo_wr with data 0..F in order; pkt_done, pkt_err=0 coincident with the 16th write.
- Padding:
  - Stimulus: same frame followed by 36 nibbles of 0 before pkt_dv falls.
  - Required: exactly 16 writes; pkt_done once.
- Checksum error:
  - Stimulus: checksum field C574.
  - Required: no hdr_ok; pkt_done, pkt_err=1, err_code=4 1 cycle after nibble 39; 0 writes.
- Filtering:
  - Stimulus: destination c0a88901 with the checksum recomputed, CHECK_DST=1.
  - Required: err_code=3.
  - Stimulus: same frame with CHECK_DST=0.
  - Required: accepted.
- Runt and truncated:
  - Stimulus: pkt_dv drops after 30 nibbles.
  - Required: err_code=6.
  - Stimulus: pkt_dv drops after 6 payload nibbles.
  - Required: 6 writes, then pkt_done with err_code=7.
- Reset mid-payload:
  - Stimulus: rst pulsed mid-payload.
  - Required: all outputs 0 immediately; no pkt_done; the next good frame is parsed correctly once pkt_dv has been low.

Source files
------------

// File: rtl/ip_rx_parser.sv
// IPv4/UDP receive parser on the MII nibble stream.
// Validates the IPv4 header and forwards UDP payload nibbles to a FIFO.
module ip_rx_parser #(
  parameter logic [31:0] LOCAL_IP  = 32'hc0a88958,
  parameter bit          CHECK_DST = 1'b1
) (
  input  logic        mii_rx_clk,
  input  logic        rst,
  input  logic        pkt_dv,
  input  logic [3:0]  pkt_da,
  output logic        fifo_wr,
  output logic [3:0]  fifo_wd,
  output logic [15:0] pay_len,
  output logic [31:0] src_ip,
  output logic        hdr_ok,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic [2:0]  err_code
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DROP
  } state_t;

  state_t      state, state_n;
  logic [5:0]  nib_cnt, nib_cnt_n;
  logic [16:0] rem, rem_n;
  logic        armed;

  logic [3:0]  lo_nib;
  logic [7:0]  hdr_b [19];
  logic [7:0]  hb [20];
  logic [7:0]  cur_b;
  logic [5:0]  nib_idx;
  logic        cap;

  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic [15:0] tot_len;
  logic [15:0] plen_c;
  logic [31:0] src_c;
  logic [31:0] dst_c;
  logic [2:0]  hdr_code;

  logic        wr_n;
  logic [3:0]  wd_n;
  logic        ok_n;
  logic        done_n;
  logic        perr_n;
  logic [2:0]  code_n;
  logic [15:0] plen_n;
  logic [31:0] sip_n;

  assign cur_b   = {pkt_da, lo_nib};
  assign nib_idx = (state == HDR) ? nib_cnt : 6'd0;
  assign cap     = pkt_dv &
                   ((state == HDR) |
                    ((state == IDLE) & armed));

  // Header byte store; byte 19 is taken straight from the bus.
  always_ff @(posedge mii_rx_clk or posedge rst) begin
    if (rst) begin
      lo_nib <= '0;
      for (int i = 0; i < 19; i++)
        hdr_b[i] <= '0;
    end else begin
      if (cap && !nib_idx[0])
        lo_nib <= pkt_da;
      if (cap && nib_idx[0] && nib_idx < 6'd38)
        hdr_b[nib_idx[5:1]] <= cur_b;
    end
  end

  always_comb begin
    for (int i = 0; i < 19; i++)
      hb[i] = hdr_b[i];
    hb[19] = cur_b;
  end

  always_comb begin
    sum = '0;
    for (int j = 0; j < 10; j++)
      sum = sum + {4'h0, hb[2*j], hb[2*j+1]};
    fold1 = {1'b0, sum[15:0]} + {13'h0, sum[19:16]};
    fold2 = fold1[15:0] + {15'h0, fold1[16]};
  end

  assign tot_len = {hb[2], hb[3]};
  assign plen_c  = tot_len - 16'd20;
  assign src_c   = {hb[12], hb[13], hb[14], hb[15]};
  assign dst_c   = {hb[16], hb[17], hb[18], hb[19]};

  always_comb begin
    hdr_code = 3'd0;
    priority case (1'b1)
      hb[0] != 8'h45:
        hdr_code = 3'd1;
      hb[9] != 8'd17:
        hdr_code = 3'd2;
      CHECK_DST && (dst_c != LOCAL_IP):
        hdr_code = 3'd3;
      fold2 != 16'hffff:
        hdr_code = 3'd4;
      (tot_len < 16'd20) || hb[6][5] ||
      ({hb[6][4:0], hb[7]} != 13'd0):
        hdr_code = 3'd5;
      default:
        hdr_code = 3'd0;
    endcase
  end

  always_comb begin
    state_n   = state;
    nib_cnt_n = nib_cnt;
    rem_n     = rem;
    wr_n      = 1'b0;
    wd_n      = fifo_wd;
    ok_n      = 1'b0;
    done_n    = 1'b0;
    perr_n    = 1'b0;
    code_n    = err_code;
    plen_n    = pay_len;
    sip_n     = src_ip;
    unique case (state)
      IDLE: begin
        if (pkt_dv && armed) begin
          state_n   = HDR;
          nib_cnt_n = 6'd1;
          code_n    = 3'd0;
        end
      end
      HDR: begin
        if (!pkt_dv) begin
          state_n   = IDLE;
          nib_cnt_n = 6'd0;
          done_n    = 1'b1;
          perr_n    = 1'b1;
          code_n    = 3'd6;
        end else if (nib_cnt == 6'd39) begin
          nib_cnt_n = 6'd0;
          if (hdr_code != 3'd0) begin
            state_n = DROP;
            done_n  = 1'b1;
            perr_n  = 1'b1;
            code_n  = hdr_code;
          end else begin
            ok_n   = 1'b1;
            plen_n = plen_c;
            sip_n  = src_c;
            rem_n  = {plen_c, 1'b0};
            if (plen_c == 16'd0) begin
              state_n = DROP;
              done_n  = 1'b1;
            end else begin
              state_n = PAYLOAD;
            end
          end
        end else begin
          nib_cnt_n = nib_cnt + 6'd1;
        end
      end
      PAYLOAD: begin
        if (!pkt_dv) begin
          state_n = IDLE;
          rem_n   = '0;
          done_n  = 1'b1;
          perr_n  = 1'b1;
          code_n  = 3'd7;
        end else begin
          wr_n  = 1'b1;
          wd_n  = pkt_da;
          rem_n = rem - 17'd1;
          if (rem == 17'd1) begin
            state_n = DROP;
            done_n  = 1'b1;
          end
        end
      end
      DROP: begin
        if (!pkt_dv)
          state_n = IDLE;
      end
    endcase
  end

  // armed blocks a frame already in flight when reset is released.
  always_ff @(posedge mii_rx_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      nib_cnt  <= '0;
      rem      <= '0;
      armed    <= 1'b0;
      fifo_wr  <= 1'b0;
      fifo_wd  <= '0;
      hdr_ok   <= 1'b0;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= '0;
      pay_len  <= '0;
      src_ip   <= '0;
    end else begin
      state    <= state_n;
      nib_cnt  <= nib_cnt_n;
      rem      <= rem_n;
      armed    <= armed | ~pkt_dv;
      fifo_wr  <= wr_n;
      fifo_wd  <= wd_n;
      hdr_ok   <= ok_n;
      pkt_done <= done_n;
      pkt_err  <= perr_n;
      err_code <= code_n;
      pay_len  <= plen_n;
      src_ip   <= sip_n;
    end
  end

endmodule

// File: tb/tb_ip_rx_parser.sv
// Bench for ip_rx_parser: vector table, random frames vs a
// byte-level reference model, and a mid-payload reset sequence.
module tb_ip_rx_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_dv;
  logic [3:0]  pkt_da;

  logic        u1_wr, u0_wr;
  logic [3:0]  u1_wd, u0_wd;
  logic [15:0] u1_plen, u0_plen;
  logic [31:0] u1_sip, u0_sip;
  logic        u1_ok, u0_ok;
  logic        u1_done, u0_done;
  logic        u1_err, u0_err;
  logic [2:0]  u1_code, u0_code;

  localparam logic [31:0] LIP = 32'hc0a88958;

  ip_rx_parser #(.LOCAL_IP(LIP), .CHECK_DST(1'b1)) u_dut1 (
    .mii_rx_clk(clk), .rst(rst),
    .pkt_dv(pkt_dv), .pkt_da(pkt_da),
    .fifo_wr(u1_wr), .fifo_wd(u1_wd),
    .pay_len(u1_plen), .src_ip(u1_sip),
    .hdr_ok(u1_ok), .pkt_done(u1_done),
    .pkt_err(u1_err), .err_code(u1_code)
  );

  ip_rx_parser #(.LOCAL_IP(LIP), .CHECK_DST(1'b0)) u_dut0 (
    .mii_rx_clk(clk), .rst(rst),
    .pkt_dv(pkt_dv), .pkt_da(pkt_da),
    .fifo_wr(u0_wr), .fifo_wd(u0_wd),
    .pay_len(u0_plen), .src_ip(u0_sip),
    .hdr_ok(u0_ok), .pkt_done(u0_done),
    .pkt_err(u0_err), .err_code(u0_code)
  );

  always #20 clk = ~clk;

  typedef struct {
    int          inst;
    int          kind;
    int          t;
    logic [3:0]  d;
    logic        err;
    logic [2:0]  code;
    logic [15:0] plen;
    logic [31:0] sip;
  } ev_t;

  typedef struct {
    logic [0:9][15:0] w;
    int nhdr, npay, npad;
    int code1, nwr1, dn1;
    int code0, nwr0, dn0;
  } vec_t;

  ev_t        ev_q[$];
  logic [3:0] fr[$];
  int         ncyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  vec_t       tbl [6];

  function automatic void chk(input string nm, input int act,
                              input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void log_ev(
    input int inst, input logic wr, input logic [3:0] wd,
    input logic ok, input logic dn, input logic er,
    input logic [2:0] cd, input logic [15:0] pl,
    input logic [31:0] ip);
    ev_t e;
    e.inst = inst; e.t = ncyc; e.d = wd; e.err = er;
    e.code = cd; e.plen = pl; e.sip = ip; e.kind = 0;
    if (wr) ev_q.push_back(e);
    e.kind = 1;
    if (ok) ev_q.push_back(e);
    e.kind = 2;
    if (dn) ev_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    log_ev(1, u1_wr, u1_wd, u1_ok, u1_done, u1_err,
           u1_code, u1_plen, u1_sip);
    log_ev(0, u0_wr, u0_wd, u0_ok, u0_done, u0_err,
           u0_code, u0_plen, u0_sip);
  end

  // Reference model: parse the frame bytes and derive every outcome.
  // Event times are in cycles after the first nibble is driven.
  function automatic void model(
    input bit cd, output bit hok, output int code,
    output int nwr, output int dn,
    output logic [15:0] plen, output logic [31:0] sip);
    int n;
    int s;
    int tot;
    logic [7:0] b [20];
    n = fr.size();
    hok = 0; code = 0; nwr = 0; dn = 0; plen = 0; sip = 0;
    if (n < 40) begin
      code = 6; dn = n + 2;
      return;
    end
    for (int k = 0; k < 20; k++) b[k] = {fr[2*k+1], fr[2*k]};
    s = 0;
    for (int j = 0; j < 10; j++) s += int'({b[2*j], b[2*j+1]});
    while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
    tot = int'({b[2], b[3]});
    if (b[0] != 8'h45) code = 1;
    else if (b[9] != 8'd17) code = 2;
    else if (cd && {b[16], b[17], b[18], b[19]} != LIP) code = 3;
    else if (s != 32'hffff) code = 4;
    else if (tot < 20 || b[6][5] || {b[6][4:0], b[7]} != 13'd0)
      code = 5;
    if (code != 0) begin
      dn = 41;
      return;
    end
    hok = 1;
    plen = 16'(tot - 20);
    sip = {b[12], b[13], b[14], b[15]};
    if (tot == 20) begin
      dn = 41;
    end else if (n - 40 >= 2 * (tot - 20)) begin
      nwr = 2 * (tot - 20); dn = 41 + nwr;
    end else begin
      nwr = n - 40; dn = n + 2; code = 7;
    end
  endfunction

  task automatic check_inst(
    input int inst, input int f0, input string tag,
    input bit hok, input int code, input int nwr, input int dn,
    input logic [15:0] plen, input logic [31:0] sip);
    int nh, nd, nw;
    nh = 0; nd = 0; nw = 0;
    foreach (ev_q[k]) begin
      if (ev_q[k].inst == inst) begin
        if (ev_q[k].kind == 0) begin
          if (nw < nwr && 40 + nw < fr.size()) begin
            chk($sformatf("%s u%0d wd%0d", tag, inst, nw),
                int'(ev_q[k].d), int'(fr[40+nw]));
            chk($sformatf("%s u%0d wt%0d", tag, inst, nw),
                ev_q[k].t - f0, 42 + nw);
          end
          nw++;
        end else if (ev_q[k].kind == 1) begin
          nh++;
          chk($sformatf("%s u%0d ok_t", tag, inst),
              ev_q[k].t - f0, 41);
          chk($sformatf("%s u%0d pay_len", tag, inst),
              int'(ev_q[k].plen), int'(plen));
          chk($sformatf("%s u%0d src_ip", tag, inst),
              int'(ev_q[k].sip), int'(sip));
        end else begin
          nd++;
          chk($sformatf("%s u%0d done_t", tag, inst),
              ev_q[k].t - f0, dn);
          chk($sformatf("%s u%0d pkt_err", tag, inst),
              int'(ev_q[k].err), (code != 0) ? 1 : 0);
          chk($sformatf("%s u%0d err_code", tag, inst),
              int'(ev_q[k].code), code);
        end
      end
    end
    chk($sformatf("%s u%0d n_ok", tag, inst), nh, int'(hok));
    chk($sformatf("%s u%0d n_wr", tag, inst), nw, nwr);
    chk($sformatf("%s u%0d n_done", tag, inst), nd, 1);
  endtask

  task automatic send_frame(output int f0);
    @(posedge clk); #1;
    f0 = ncyc;
    foreach (fr[i]) begin
      pkt_dv = 1'b1; pkt_da = fr[i];
      @(posedge clk); #1;
    end
    pkt_dv = 1'b0; pkt_da = 4'h0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fr.push_back(b[3:0]);
    fr.push_back(b[7:4]);
  endtask

  task automatic build_vec(input vec_t v);
    fr.delete();
    for (int k = 0; k < 10; k++) begin
      push_byte(v.w[k][15:8]);
      push_byte(v.w[k][7:0]);
    end
    while (fr.size() > v.nhdr) void'(fr.pop_back());
    for (int i = 0; i < v.npay; i++) fr.push_back(4'(i));
    for (int i = 0; i < v.npad; i++) fr.push_back(4'h0);
  endtask

  task automatic build_rand();
    logic [7:0]  b [20];
    logic [15:0] cs;
    int mode, plen, s, npad, n;
    mode = $urandom_range(0, 10);
    plen = $urandom_range(0, 12);
    b[0] = 8'h45;  b[1] = 8'($urandom);
    b[2] = 8'h00;  b[3] = 8'(20 + plen);
    b[4] = 8'($urandom); b[5] = 8'($urandom);
    b[6] = ($urandom_range(0, 1) != 0) ? 8'h40 : 8'h00;
    b[7] = 8'h00;  b[8] = 8'($urandom);
    b[9] = 8'd17;  b[10] = 8'h00; b[11] = 8'h00;
    for (int k = 12; k < 16; k++) b[k] = 8'($urandom);
    {b[16], b[17], b[18], b[19]} =
      ($urandom_range(0, 3) == 0) ? 32'($urandom) : LIP;
    case (mode)
      3: b[0] = 8'h46;
      4: b[9] = 8'h06;
      5: b[6] = b[6] | 8'h20;
      6: b[7] = 8'($urandom_range(1, 255));
      7: b[3] = 8'($urandom_range(0, 19));
      default: ;
    endcase
    s = 0;
    for (int j = 0; j < 10; j++) s += int'({b[2*j], b[2*j+1]});
    while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
    cs = ~16'(s);
    b[10] = cs[15:8]; b[11] = cs[7:0];
    if (mode == 8) b[11] = b[11] ^ 8'(1 << $urandom_range(0, 7));
    fr.delete();
    for (int k = 0; k < 20; k++) push_byte(b[k]);
    for (int i = 0; i < 2 * plen; i++) fr.push_back(4'($urandom));
    npad = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0;
    for (int i = 0; i < npad; i++) fr.push_back(4'h0);
    if ($urandom_range(0, 4) == 0) begin
      n = $urandom_range(1, fr.size() - 1);
      while (fr.size() > n) void'(fr.pop_back());
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " u1 fifo_wr"}, int'(u1_wr), 0);
    chk({tag, " u1 fifo_wd"}, int'(u1_wd), 0);
    chk({tag, " u1 pay_len"}, int'(u1_plen), 0);
    chk({tag, " u1 src_ip"}, int'(u1_sip), 0);
    chk({tag, " u1 hdr_ok"}, int'(u1_ok), 0);
    chk({tag, " u1 pkt_done"}, int'(u1_done), 0);
    chk({tag, " u1 pkt_err"}, int'(u1_err), 0);
    chk({tag, " u1 err_code"}, int'(u1_code), 0);
    chk({tag, " u0 fifo_wr"}, int'(u0_wr), 0);
    chk({tag, " u0 pay_len"}, int'(u0_plen), 0);
    chk({tag, " u0 src_ip"}, int'(u0_sip), 0);
    chk({tag, " u0 pkt_done"}, int'(u0_done), 0);
  endtask

  localparam logic [0:9][15:0] W_GOOD = {
    16'h4500, 16'h001C, 16'h21B3, 16'h0000, 16'h4011,
    16'hC573, 16'hC0A8, 16'h8901, 16'hC0A8, 16'h8958};
  localparam logic [0:9][15:0] W_CSUM = {
    16'h4500, 16'h001C, 16'h21B3, 16'h0000, 16'h4011,
    16'hC574, 16'hC0A8, 16'h8901, 16'hC0A8, 16'h8958};
  localparam logic [0:9][15:0] W_DST = {
    16'h4500, 16'h001C, 16'h21B3, 16'h0000, 16'h4011,
    16'hC5CA, 16'hC0A8, 16'h8901, 16'hC0A8, 16'h8901};

  initial begin
    int f0;
    bit hok;
    int code, nwr, dn;
    logic [15:0] plen;
    logic [31:0] sip;
    int nw, nh, nd;

    tbl[0] = '{W_GOOD, 40, 16, 0,  0, 16, 57,  0, 16, 57};
    tbl[1] = '{W_GOOD, 40, 16, 36, 0, 16, 57,  0, 16, 57};
    tbl[2] = '{W_CSUM, 40, 16, 0,  4, 0,  41,  4, 0,  41};
    tbl[3] = '{W_DST,  40, 16, 0,  3, 0,  41,  0, 16, 57};
    tbl[4] = '{W_GOOD, 30, 0,  0,  6, 0,  32,  6, 0,  32};
    tbl[5] = '{W_GOOD, 40, 6,  0,  7, 6,  48,  7, 6,  48};

    rst = 1'b1; pkt_dv = 1'b0; pkt_da = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ev_q.delete();

    for (int v = 0; v < 6; v++) begin
      build_vec(tbl[v]);
      send_frame(f0);
      check_inst(1, f0, $sformatf("vec%0d", v),
                 tbl[v].code1 == 0 || tbl[v].code1 == 7,
                 tbl[v].code1, tbl[v].nwr1, tbl[v].dn1,
                 16'd8, 32'hc0a88901);
      check_inst(0, f0, $sformatf("vec%0d", v),
                 tbl[v].code0 == 0 || tbl[v].code0 == 7,
                 tbl[v].code0, tbl[v].nwr0, tbl[v].dn0,
                 16'd8, 32'hc0a88901);
      ev_q.delete();
    end

    for (int r = 0; r < 40; r++) begin
      build_rand();
      send_frame(f0);
      model(1'b1, hok, code, nwr, dn, plen, sip);
      check_inst(1, f0, $sformatf("rnd%0d", r),
                 hok, code, nwr, dn, plen, sip);
      model(1'b0, hok, code, nwr, dn, plen, sip);
      check_inst(0, f0, $sformatf("rnd%0d", r),
                 hok, code, nwr, dn, plen, sip);
      ev_q.delete();
    end

    build_vec(tbl[0]);
    @(posedge clk); #1;
    f0 = ncyc;
    for (int i = 0; i < 45; i++) begin
      pkt_dv = 1'b1; pkt_da = fr[i];
      @(posedge clk); #1;
    end
    rst = 1'b1; pkt_da = fr[45];
    #1;
    check_zero("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 46; i < 52; i++) begin
      pkt_da = fr[i];
      @(posedge clk); #1;
    end
    pkt_dv = 1'b0; pkt_da = 4'h0;
    repeat (4) @(posedge clk);
    #1;
    nw = 0; nh = 0; nd = 0;
    foreach (ev_q[k]) begin
      if (ev_q[k].inst == 1) begin
        if (ev_q[k].kind == 0) nw++;
        else if (ev_q[k].kind == 1) nh++;
        else nd++;
      end
    end
    chk("rst_mid n_wr", nw, 4);
    chk("rst_mid n_ok", nh, 1);
    chk("rst_mid n_done", nd, 0);
    ev_q.delete();

    build_vec(tbl[0]);
    send_frame(f0);
    check_inst(1, f0, "after_rst", 1'b1, 0, 16, 57,
               16'd8, 32'hc0a88901);
    ev_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
